// File: rtl/skin_bbox_overlay.sv
// Skin classifier on an HSV pixel stream with per-frame bounding-box tracking
// and an RGB overlay: skin white, background black, previous frame's box red.
module skin_bbox_overlay #(
    parameter logic [7:0]  H_MIN      = 8'd0,
    parameter logic [7:0]  H_MAX      = 8'd25,
    parameter logic [7:0]  S_MIN      = 8'd40,
    parameter logic [7:0]  S_MAX      = 8'd170,
    parameter logic [7:0]  V_MIN      = 8'd60,
    parameter logic [19:0] MIN_PIXELS = 20'd64,
    parameter int          CW         = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic          de_in,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic [7:0]    H,
    input  logic [7:0]    S,
    input  logic [7:0]    V,
    output logic          de_out,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic [7:0]    bined,
    output logic [7:0]    r_out,
    output logic [7:0]    g_out,
    output logic [7:0]    b_out,
    output logic [CW-1:0] x_min,
    output logic [CW-1:0] x_max,
    output logic [CW-1:0] y_min,
    output logic [CW-1:0] y_max,
    output logic          box_valid
);

    localparam logic [CW-1:0] C_MAX    = '1;
    localparam logic [19:0]   CNT_MAX  = '1;
    // Window length minus one, modulo 256; covers both plain and wrapping windows.
    localparam logic [7:0]    HUE_SPAN = H_MAX - H_MIN;

    // Input-side edge detectors and position counters
    logic          de_prev;
    logic          vs_prev;
    logic [CW-1:0] x_cnt;
    logic [CW-1:0] y_cnt;

    // Current-frame accumulators
    logic [CW-1:0] acc_xmin;
    logic [CW-1:0] acc_xmax;
    logic [CW-1:0] acc_ymin;
    logic [CW-1:0] acc_ymax;
    logic [19:0]   acc_cnt;
    logic          frame_ok;

    // Pipeline stage 1
    logic          s1_de;
    logic          s1_hs;
    logic          s1_vs;
    logic          s1_skin;
    logic [CW-1:0] s1_x;
    logic [CW-1:0] s1_y;

    logic [7:0]    hue_off;
    logic          hue_ok;
    logic          skin;
    logic          de_fall;
    logic          vs_rise;

    always_comb begin
        hue_off = H - H_MIN;
        hue_ok  = (hue_off <= HUE_SPAN);
        skin    = de_in & hue_ok & (S >= S_MIN) & (S <= S_MAX) & (V >= V_MIN);
        de_fall = de_prev & ~de_in;
        vs_rise = vsync_in & ~vs_prev;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_prev <= 1'b0;
            vs_prev <= 1'b0;
            x_cnt   <= '0;
            y_cnt   <= '0;
        end else if (ce) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register in this clock domain samples the pre-edge values.
            de_prev <= de_in;
            vs_prev <= vsync_in;
            if (de_in) begin
                if (x_cnt != C_MAX) begin
                    x_cnt <= x_cnt + CW'(1);
                end
            end else if (de_fall) begin
                x_cnt <= '0;
            end
            if (vs_rise) begin
                y_cnt <= '0;
            end else if (de_fall && (y_cnt != C_MAX)) begin
                y_cnt <= y_cnt + CW'(1);
            end
        end
    end

    // A skin pixel coinciding with the vsync edge is dropped; the edge wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_xmin  <= '1;
            acc_xmax  <= '0;
            acc_ymin  <= '1;
            acc_ymax  <= '0;
            acc_cnt   <= '0;
            frame_ok  <= 1'b0;
            x_min     <= '0;
            x_max     <= '0;
            y_min     <= '0;
            y_max     <= '0;
            box_valid <= 1'b0;
        end else if (ce) begin
            if (vs_rise) begin
                x_min     <= acc_xmin;
                x_max     <= acc_xmax;
                y_min     <= acc_ymin;
                y_max     <= acc_ymax;
                box_valid <= frame_ok & (acc_cnt >= MIN_PIXELS);
                acc_xmin  <= '1;
                acc_xmax  <= '0;
                acc_ymin  <= '1;
                acc_ymax  <= '0;
                acc_cnt   <= '0;
                frame_ok  <= 1'b1;
            end else if (skin) begin
                if (x_cnt < acc_xmin) acc_xmin <= x_cnt;
                if (x_cnt > acc_xmax) acc_xmax <= x_cnt;
                if (y_cnt < acc_ymin) acc_ymin <= y_cnt;
                if (y_cnt > acc_ymax) acc_ymax <= y_cnt;
                if (acc_cnt != CNT_MAX) begin
                    acc_cnt <= acc_cnt + 20'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_de   <= 1'b0;
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
            s1_skin <= 1'b0;
            s1_x    <= '0;
            s1_y    <= '0;
        end else if (ce) begin
            s1_de   <= de_in;
            s1_hs   <= hsync_in;
            s1_vs   <= vsync_in;
            s1_skin <= skin;
            s1_x    <= x_cnt;
            s1_y    <= y_cnt;
        end
    end

    logic        col_hit;
    logic        row_hit;
    logic        on_edge;
    logic [23:0] rgb_nxt;

    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        rgb_nxt = 24'h000000;
        col_hit = ((s1_x == x_min) || (s1_x == x_max)) && (s1_y >= y_min) && (s1_y <= y_max);
        row_hit = ((s1_y == y_min) || (s1_y == y_max)) && (s1_x >= x_min) && (s1_x <= x_max);
        on_edge = box_valid & s1_de & (col_hit | row_hit);
        if (on_edge) begin
            rgb_nxt = 24'hFF0000;
        end else if (s1_skin) begin
            rgb_nxt = 24'hFFFFFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_out    <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            bined     <= 8'h00;
            r_out     <= 8'h00;
            g_out     <= 8'h00;
            b_out     <= 8'h00;
        end else if (ce) begin
            de_out    <= s1_de;
            hsync_out <= s1_hs;
            vsync_out <= s1_vs;
            bined     <= s1_skin ? 8'hFF : 8'h00;
            {r_out, g_out, b_out} <= rgb_nxt;
        end
    end

endmodule

// File: tb/tb_skin_bbox_overlay.sv
// Directed bench: three instances (default, MIN_PIXELS=16, wrapping hue window)
// share one stimulus; each output is checked two cycles after its pixel.
module tb_skin_bbox_overlay;

    localparam int CW = 11;
    localparam int ND = 3;

    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic [2:0] skin;
        logic [2:0] red;
    } exp_t;

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] s;
        logic [7:0] v;
        logic [2:0] sk;
    } hv_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic          de_in;
    logic          hsync_in;
    logic          vsync_in;
    logic [7:0]    h_in;
    logic [7:0]    s_in;
    logic [7:0]    v_in;
    logic [ND-1:0] de_o;
    logic [ND-1:0] hs_o;
    logic [ND-1:0] vs_o;
    logic [ND-1:0] bv_o;
    logic [7:0]    bined_o [ND];
    logic [7:0]    r_o [ND];
    logic [7:0]    g_o [ND];
    logic [7:0]    b_o [ND];
    logic [CW-1:0] xmn_o [ND];
    logic [CW-1:0] xmx_o [ND];
    logic [CW-1:0] ymn_o [ND];
    logic [CW-1:0] ymx_o [ND];

    int            n_checks = 0;
    int            n_fail   = 0;
    exp_t          q[$];
    logic [34:0]   last_exp [ND];
    logic [ND-1:0] eb_valid;
    int            eb_xmn, eb_xmx, eb_ymn, eb_ymx;
    hv_t           hue_tbl [16];

    always #5 clk = ~clk;

    for (genvar d = 0; d < ND; d++) begin : g_dut
        skin_bbox_overlay #(
            .H_MIN      (d == 2 ? 8'd240 : 8'd0),
            .H_MAX      (d == 2 ? 8'd20 : 8'd25),
            .MIN_PIXELS (d == 1 ? 20'd16 : 20'd64),
            .CW         (CW)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .ce        (ce),
            .de_in     (de_in),
            .hsync_in  (hsync_in),
            .vsync_in  (vsync_in),
            .H         (h_in),
            .S         (s_in),
            .V         (v_in),
            .de_out    (de_o[d]),
            .hsync_out (hs_o[d]),
            .vsync_out (vs_o[d]),
            .bined     (bined_o[d]),
            .r_out     (r_o[d]),
            .g_out     (g_o[d]),
            .b_out     (b_o[d]),
            .x_min     (xmn_o[d]),
            .x_max     (xmx_o[d]),
            .y_min     (ymn_o[d]),
            .y_max     (ymx_o[d]),
            .box_valid (bv_o[d])
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [34:0] out_vec(input int d);
        return {de_o[d], hs_o[d], vs_o[d], bined_o[d], r_o[d], g_o[d], b_o[d]};
    endfunction

    function automatic logic [34:0] exp_vec(input exp_t e, input int d);
        logic [23:0] rgb;
        rgb = e.red[d] ? 24'hFF0000 : (e.skin[d] ? 24'hFFFFFF : 24'h000000);
        return {e.de, e.hs, e.vs, (e.skin[d] ? 8'hFF : 8'h00), rgb};
    endfunction

    function automatic logic on_box(input int x, input int y);
        return (((x == eb_xmn) || (x == eb_xmx)) && (y >= eb_ymn) && (y <= eb_ymx)) ||
               (((y == eb_ymn) || (y == eb_ymx)) && (x >= eb_xmn) && (x <= eb_xmx));
    endfunction

    task automatic check_box(input string tag);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("%s x_min d%0d", tag, d), 64'(xmn_o[d]), 64'(eb_xmn));
            check($sformatf("%s x_max d%0d", tag, d), 64'(xmx_o[d]), 64'(eb_xmx));
            check($sformatf("%s y_min d%0d", tag, d), 64'(ymn_o[d]), 64'(eb_ymn));
            check($sformatf("%s y_max d%0d", tag, d), 64'(ymx_o[d]), 64'(eb_ymx));
            check($sformatf("%s box_valid d%0d", tag, d), 64'(bv_o[d]), 64'(eb_valid[d]));
        end
    endtask

    // One enabled cycle; compares outputs against the entry driven one cycle earlier.
    task automatic drive(input logic de, input logic hs, input logic vs,
                         input logic [7:0] hh, input logic [7:0] ss, input logic [7:0] vv,
                         input logic [2:0] skn, input int x, input int y);
        exp_t e;
        ce       = 1'b1;
        de_in    = de;
        hsync_in = hs;
        vsync_in = vs;
        h_in     = hh;
        s_in     = ss;
        v_in     = vv;
        e.de   = de;
        e.hs   = hs;
        e.vs   = vs;
        e.skin = skn;
        for (int d = 0; d < ND; d++) e.red[d] = eb_valid[d] & de & on_box(x, y);
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() >= 2) begin
            e = q.pop_front();
            for (int d = 0; d < ND; d++) begin
                last_exp[d] = exp_vec(e, d);
                check($sformatf("pixel d%0d", d), 64'(out_vec(d)), 64'(last_exp[d]));
            end
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 8'd10, 8'd100, 8'd200, 3'b000, 0, 0);
    endtask

    task automatic apply_reset(input int n);
        exp_t z;
        z        = '0;
        rst_n    = 1'b0;
        ce       = 1'b0;
        de_in    = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        h_in     = 8'd10;
        s_in     = 8'd100;
        v_in     = 8'd200;
        eb_valid = '0;
        eb_xmn = 0; eb_xmx = 0; eb_ymn = 0; eb_ymx = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < ND; d++) check($sformatf("reset out d%0d", d), 64'(out_vec(d)), 64'd0);
            check_box("reset");
        end
        rst_n = 1'b1;
        q.delete();
        q.push_back(z);
        for (int d = 0; d < ND; d++) last_exp[d] = '0;
    endtask

    // ce low with junk inputs: nothing may move.
    task automatic freeze(input int n);
        repeat (n) begin
            ce       = 1'b0;
            de_in    = ~de_in;
            hsync_in = 1'b1;
            vsync_in = 1'b1;
            h_in     = 8'($urandom);
            @(posedge clk);
            #1;
            for (int d = 0; d < ND; d++) check($sformatf("frozen out d%0d", d), 64'(out_vec(d)), 64'(last_exp[d]));
            check_box("frozen");
        end
    endtask

    task automatic do_line(input int mode, input int y, input int ce_x, input int rst_x);
        logic sk;
        drive(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 3'b000, 0, y);
        idle();
        idle();
        for (int x = 0; x < 16; x++) begin
            if (x == ce_x) freeze(5);
            if (x == rst_x) apply_reset(2);
            sk = (mode == 0) || (x >= 4 && x <= 9 && y >= 2 && y <= 5);
            drive(1'b1, 1'b0, 1'b0, (sk ? 8'd10 : 8'd128), 8'd100, 8'd200, {3{sk}}, x, y);
        end
        idle();
        idle();
    endtask

    // Eight 16-pixel lines, then the vsync that closes the frame.
    task automatic do_frame(input int mode, input int ce_line, input int ce_x,
                            input int rst_line, input int rst_x,
                            input int xmn, input int xmx, input int ymn, input int ymx,
                            input logic [2:0] v);
        for (int y = 0; y < 8; y++) begin
            do_line(mode, y, (y == ce_line) ? ce_x : -1, (y == rst_line) ? rst_x : -1);
        end
        idle();
        drive(1'b0, 1'b0, 1'b1, 8'd10, 8'd100, 8'd200, 3'b000, 0, 0);
        eb_xmn = xmn; eb_xmx = xmx; eb_ymn = ymn; eb_ymx = ymx;
        eb_valid = v;
        check_box("frame end");
        drive(1'b0, 1'b0, 1'b1, 8'd10, 8'd100, 8'd200, 3'b000, 0, 0);
        idle();
        idle();
        check_box("frame hold");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // sk bits are {wrap-hue dut, MIN16 dut, default dut}
        hue_tbl = '{
            '{8'd10,  8'd100, 8'd200, 3'b111}, '{8'd250, 8'd100, 8'd200, 3'b100},
            '{8'd5,   8'd100, 8'd200, 3'b111}, '{8'd100, 8'd100, 8'd200, 3'b000},
            '{8'd10,  8'd100, 8'd59,  3'b000}, '{8'd10,  8'd171, 8'd200, 3'b000},
            '{8'd10,  8'd170, 8'd60,  3'b111}, '{8'd10,  8'd40,  8'd200, 3'b111},
            '{8'd10,  8'd39,  8'd200, 3'b000}, '{8'd25,  8'd100, 8'd200, 3'b011},
            '{8'd26,  8'd100, 8'd200, 3'b000}, '{8'd240, 8'd100, 8'd200, 3'b100},
            '{8'd20,  8'd100, 8'd200, 3'b111}, '{8'd21,  8'd100, 8'd200, 3'b011},
            '{8'd239, 8'd100, 8'd200, 3'b000}, '{8'd0,   8'd100, 8'd200, 3'b111}
        };

        // Full-skin frames; second frame has a 5-cycle ce=0 gap mid-line.
        apply_reset(3);
        do_frame(0, -1, -1, -1, -1, 0, 15, 0, 7, 3'b000);
        do_frame(0, 3, 5, -1, -1, 0, 15, 0, 7, 3'b111);
        do_frame(0, -1, -1, -1, -1, 0, 15, 0, 7, 3'b111);

        // 24-pixel block: only the MIN_PIXELS=16 instance reports a valid box.
        apply_reset(2);
        do_frame(1, -1, -1, -1, -1, 4, 9, 2, 5, 3'b000);
        do_frame(1, -1, -1, -1, -1, 4, 9, 2, 5, 3'b010);
        do_frame(1, -1, -1, -1, -1, 4, 9, 2, 5, 3'b010);

        // Reset in the middle of line 3 of frame 2: x/y restart, box stays invalid.
        apply_reset(2);
        do_frame(0, -1, -1, -1, -1, 0, 15, 0, 7, 3'b000);
        do_frame(0, -1, -1, 3, 8, 0, 15, 0, 4, 3'b000);
        do_frame(0, -1, -1, -1, -1, 0, 15, 0, 7, 3'b111);
        do_frame(0, -1, -1, -1, -1, 0, 15, 0, 7, 3'b111);

        // Hue window and S/V boundaries, one pixel per table row.
        apply_reset(2);
        drive(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 3'b000, 0, 0);
        idle();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 1'b0, hue_tbl[i].h, hue_tbl[i].s, hue_tbl[i].v, hue_tbl[i].sk, i, 0);
        end
        repeat (4) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
